// File: rtl/m31_bricks_seq.sv
// Sequential Monolith "Bricks" layer over GF(2^31-1):
//   y_0 = x_0,  y_i = x_i + x_{i-1}^2 mod p.
// One word is updated per cycle, highest index first, through a single
// combinational m31_multiplier squaring W[idx-1].

// Combinational Mersenne-31 multiplier with full reduction to [0, p-1].
module m31_multiplier (
  input  logic [30:0] a,
  input  logic [30:0] b,
  output logic [30:0] y
);
  localparam logic [31:0] P = 32'h7FFF_FFFF;

  logic [61:0] prod;
  logic [31:0] s;
  logic [31:0] t;

  // 2^31 == 1 mod p: fold the high half onto the low half twice, then one
  // conditional subtract handles the t == p corner.
  always_comb begin
    prod = {31'b0, a} * {31'b0, b};
    s    = {1'b0, prod[30:0]} + {1'b0, prod[61:31]};
    t    = {1'b0, s[30:0]} + {31'b0, s[31]};
    y    = (t >= P) ? 31'(t - P) : t[30:0];
  end
endmodule

module m31_bricks_seq #(
  parameter int STATE_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31*STATE_WIDTH-1:0]   in_state,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31*STATE_WIDTH-1:0]   out_state
);
  localparam int          IW = (STATE_WIDTH > 1) ? $clog2(STATE_WIDTH) : 1;
  localparam logic [31:0] P  = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state, state_nx;
  logic [STATE_WIDTH-1:0][30:0]    w;
  logic [STATE_WIDTH-1:0][30:0]    in_canon;
  logic [IW-1:0]                   idx;
  logic [IW-1:0]                   prev;
  logic [30:0]                     sq;
  logic [31:0]                     sum_raw;
  logic [30:0]                     sum;
  logic                            load;

  // Canonicalise incoming words: the only non-canonical 31-bit value is p.
  always_comb begin
    in_canon = '0;
    for (int i = 0; i < STATE_WIDTH; i++) begin
      in_canon[i] = (in_state[31*i +: 31] == P[30:0]) ? 31'd0 : in_state[31*i +: 31];
    end
  end

  // Source word for the square; clamped so idx == 0 never reads out of range.
  always_comb begin
    prev = (idx == '0) ? '0 : idx - IW'(1);
  end

  m31_multiplier u_mul (
    .a (w[prev]),
    .b (w[prev]),
    .y (sq)
  );

  // modadd: both operands canonical, so one conditional subtract suffices.
  always_comb begin
    sum_raw = {1'b0, w[idx]} + {1'b0, sq};
    sum     = (sum_raw >= P) ? 31'(sum_raw - P) : sum_raw[30:0];
  end

  // Handshakes and next-state; in_ready masked while reset is held.
  always_comb begin
    state_nx  = state;
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    load      = in_valid && in_ready;
    case (state)
      IDLE:    if (load) state_nx = RUN;
      RUN:     if (idx == IW'(1)) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, index and word file. Descending order means W[idx-1] is still
  // the original input when squared, so no snapshot copy is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      w     <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        w   <= in_canon;
        idx <= IW'(STATE_WIDTH - 1);
      end else if (state == RUN) begin
        w[idx] <= sum;
        if (idx != IW'(1)) idx <= idx - IW'(1);
      end
    end
  end

  assign out_state = w;

endmodule

// File: tb/tb_m31_bricks_seq.sv
// Directed bench for m31_bricks_seq (STATE_WIDTH = 16).
module tb_m31_bricks_seq;
  localparam int          SW = 16;
  localparam logic [30:0] P  = 31'h7FFF_FFFF;
  typedef logic [31*SW-1:0] vec_t;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  vec_t in_state, out_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  m31_bricks_seq #(.STATE_WIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [30:0] wd(input vec_t v, input int i);
    return v[31*i +: 31];
  endfunction

  // Reference model using plain modular arithmetic.
  function automatic vec_t model(input vec_t x);
    vec_t y;
    longint unsigned a, b;
    y = '0;
    for (int i = 0; i < SW; i++) begin
      a = (longint'(wd(x, i)) == longint'(P)) ? 0 : longint'(wd(x, i));
      if (i == 0) begin
        y[0 +: 31] = 31'(a);
      end else begin
        b = (longint'(wd(x, i-1)) == longint'(P)) ? 0 : longint'(wd(x, i-1));
        y[31*i +: 31] = 31'((a + (b * b) % longint'(P)) % longint'(P));
      end
    end
    return y;
  endfunction

  // Present a vector at the current negedge, wait for out_valid, check latency.
  task automatic send(input vec_t v, input string tag);
    int n;
    in_state = v;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, vec_t'(in_ready), vec_t'(1));
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, vec_t'(n), vec_t'(16));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, vec_t'(out_valid), vec_t'(0));
    chk({tag, "_ir_back"}, vec_t'(in_ready), vec_t'(1));
  endtask

  vec_t ramp, ramp_exp, va, vb, vc, held, v4[4];
  int   seen, acc, prev_acc, n;

  initial begin
    for (int i = 0; i < SW; i++) begin
      ramp[31*i +: 31]     = 31'(i + 1);
      ramp_exp[31*i +: 31] = 31'((i + 1) + i * i);
    end

    // Reset held with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; in_state = ramp; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_in_ready", vec_t'(in_ready), vec_t'(0));
      chk("rst_out_valid", vec_t'(out_valid), vec_t'(0));
      chk("rst_out_state", out_state, '0);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", vec_t'(in_ready), vec_t'(1));

    // Ramp
    send(ramp, "ramp");
    chk("ramp_out", out_state, ramp_exp);
    chk("ramp_y15", vec_t'(wd(out_state, 15)), vec_t'(241));
    drain("ramp");

    // Field wrap cases
    va = '0; va[0 +: 31] = P - 31'd1; va[31 +: 31] = 31'd1;
    send(va, "wrapA");
    chk("wrapA_y1", vec_t'(wd(out_state, 1)), vec_t'(2));
    chk("wrapA_out", out_state, model(va));
    drain("wrapA");

    vb = '0; vb[0 +: 31] = 31'd2; vb[31 +: 31] = P - 31'd1;
    send(vb, "wrapB");
    chk("wrapB_y1", vec_t'(wd(out_state, 1)), vec_t'(3));
    chk("wrapB_out", out_state, model(vb));
    drain("wrapB");

    vc = '0; vc[0 +: 31] = P; vc[31 +: 31] = 31'd5;
    send(vc, "wrapC");
    chk("wrapC_y0", vec_t'(wd(out_state, 0)), vec_t'(0));
    chk("wrapC_y1", vec_t'(wd(out_state, 1)), vec_t'(5));
    chk("wrapC_y3", vec_t'(wd(out_state, 3)), vec_t'(0));
    drain("wrapC");

    // Backpressure with in_valid/in_state churning
    send(ramp, "bp");
    held = out_state;
    chk("bp_first", held, ramp_exp);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_state = {16{31'(32'h1234_5678 + k)}};
      @(negedge clk);
      chk("bp_hold_state", out_state, held);
      chk("bp_hold_valid", vec_t'(out_valid), vec_t'(1));
      chk("bp_in_ready", vec_t'(in_ready), vec_t'(0));
    end
    in_valid = 1'b0;
    drain("bp");
    chk("bp_not_captured", out_state, ramp_exp);

    // Mid-run reset pulse at acceptance + 5
    in_state = model(ramp);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", vec_t'(seen), vec_t'(0));
    chk("midrst_in_ready", vec_t'(in_ready), vec_t'(1));
    send(ramp, "after_rst");
    chk("after_rst_out", out_state, ramp_exp);
    drain("after_rst");

    // Back-to-back with in_valid and out_ready held high
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < SW; i++) v4[k][31*i +: 31] = 31'($urandom_range(32'h7FFF_FFFE, 0));
    end
    in_valid = 1'b1; out_ready = 1'b1; prev_acc = 0;
    for (int k = 0; k < 4; k++) begin
      in_state = v4[k];
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      acc = cyc + 1;
      if (k > 0) chk("b2b_spacing", vec_t'(acc - prev_acc), vec_t'(17));
      prev_acc = acc;
      @(negedge clk);
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_out", out_state, model(v4[k]));
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", vec_t'(out_valid), vec_t'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
